uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter BAUD_DIV, default 16, SHALL set clk cycles per bit; legal minimum 2.
REQ-003 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set transmit FIFO entries; power of two, minimum 2.
REQ-005 Ports SHALL be:
 clk  in  1  single clock, all logic on rising edge
 reset_n  in  1  asynchronous, active-low reset
 in_data  in  DATA_W  word to transmit
 in_valid  in  1  word present on in_data
 in_ready  out  1  FIFO can accept a word
 parity_en  in  1  1 = append parity bit
 parity_odd  in  1  1 = odd parity, 0 = even
 tx  out  1  serial line, idle high
 tx_busy  out  1  frame in progress
 tx_done  out  1  one-cycle pulse at end of each frame
 fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO

Function
REQ-006 A word SHALL be written to the FIFO on every rising edge where in_valid and in_ready are both 1.
REQ-007 in_ready SHALL equal NOT full; a write while full SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-008 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-009 In IDLE with FIFO non-empty, the FSM SHALL pop one word, latch it with parity_en/parity_odd, and enter START on the same edge; tx SHALL fall one cycle after the word is written into an empty FIFO with FSM idle.
REQ-010 Each bit SHALL last exactly BAUD_DIV cycles, timed by a divider counter cleared on every state entry.
REQ-011 START drives tx=0; DATA drives the latched word LSB first for DATA_W bits; PARITY (entered only if latched parity_en=1) drives XOR of data bits XOR parity_odd; STOP drives tx=1 for STOP_BITS bit times.
REQ-012 At the end of the final stop bit, tx_done SHALL pulse high for exactly one cycle; the FSM SHALL enter START directly (no idle cycle) if the FIFO is non-empty, otherwise IDLE.
REQ-013 tx_busy SHALL be 1 in every state except IDLE.
REQ-014 Changes to parity_en/parity_odd mid-frame SHALL NOT affect the frame in progress.
REQ-015 fifo_count SHALL increment on write-only, decrement on pop-only, and be unchanged on simultaneous write and pop; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 tx SHALL be 1 whenever the FSM is in IDLE.

Reset
REQ-017 reset_n=0 SHALL immediately force tx=1, tx_busy=0, tx_done=0, FSM=IDLE, divider=0, bit counter=0, FIFO pointers and fifo_count=0, in_ready=1.
REQ-018 Reset asserted mid-frame SHALL abort the frame and discard all queued words; no partial frame SHALL resume after release.
REQ-019 Data registers (shift register, FIFO storage) need no reset.

Structure
REQ-020 Shared package uart_pkg SHALL hold the FSM state enumeration and parity-mode constants, for reuse by a future receiver.
REQ-021 The FIFO SHALL be a separate sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated once.
REQ-022 Divider counter width SHALL be $clog2(BAUD_DIV); bit counter width SHALL be $clog2(DATA_W+1).

Verification (DATA_W=8, BAUD_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-023 Push 0xA5, parity off, STOP_BITS=1 -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles), tx_done one-cycle pulse at end, tx_busy then 0.
REQ-024 Push 0x07 with parity_en=1: parity_odd=0 -> parity bit 1; parity_odd=1 -> parity bit 0; frame length 44 cycles.
REQ-025 Push 6 words on consecutive cycles into empty idle block -> words 1-5 accepted (word 1 popped after one cycle, fifo_count reaches 4), in_ready=0 for word 6 until the first frame's tx_done, then accepted; all 6 transmitted in order.
REQ-026 STOP_BITS=2, two queued words -> stop high exactly 8 cycles, next start bit immediately following, no idle cycle, tx_busy held 1 across frames.
REQ-027 Assert reset_n=0 during data bit 3 with 2 words queued -> tx=1 and tx_busy=0 asynchronously, fifo_count=0; after release tx stays 1 with no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode constants.
// Kept separate so a future receiver can reuse the same encodings.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle   = 3'd0;
  localparam uart_state_t StStart  = 3'd1;
  localparam uart_state_t StData   = 3'd2;
  localparam uart_state_t StParity = 3'd3;
  localparam uart_state_t StStop   = 3'd4;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  // data_xor is the XOR reduction of the data bits.
  function automatic logic parity_bit(input logic data_xor, input logic mode);
    return (mode == ParityOdd) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed, optional parity, 1 or 2 stop bits.
// Frames run back-to-back without an idle bit while the FIFO holds words.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DivW = $clog2(BAUD_DIV);
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(BAUD_DIV - 1);
  localparam logic [DivW-1:0] DivOne   = DivW'(1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  uart_state_t       state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              done_q, done_d;
  logic              load;
  logic              bit_end;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_q;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;

  assign in_ready = ~fifo_full;
  assign bit_end  = (div_q == DivLast);

  uart_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (in_valid & ~fifo_full),
    .wdata  (in_data),
    .pop    (load),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + DivOne;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          div_d     = '0;
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + CntOne;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            // Chain straight into the next start bit when more words wait.
            if (!fifo_empty) begin
              load    = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntOne;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        div_d     = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // Parity settings are captured with the word so mid-frame changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q  <= fifo_rdata;
      par_en_q <= parity_en;
      par_q    <= parity_bit(^fifo_rdata, parity_odd);
    end else if (state_q == StData && bit_end) begin
      shift_q <= {1'b0, shift_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = shift_q[0];
      StParity: tx = par_q;
      default:  tx = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != StIdle);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: two instances (1 and 2 stop bits) share a
// line monitor that checks every frame against a queue of expected frames.
module tb_uart_tx_param;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int DEP = 4;

  typedef struct packed {
    logic [11:0] bits;
    logic [3:0]  nbits;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          valid1 = 1'b0, valid2 = 1'b0;
  logic          parity_en = 1'b0, parity_odd = 1'b0;
  logic          sel = 1'b0;
  bit            mon_en = 1'b0;

  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;
  logic [2:0] count1, count2;
  logic       m_tx, m_busy, m_done;

  frame_t exp_q[$];
  int     n_total = 0;
  int     n_pass  = 0;

  assign m_tx   = sel ? tx2 : tx1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W(DW), .BAUD_DIV(DIV), .STOP_BITS(1), .FIFO_DEPTH(DEP)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(valid1),
    .in_ready(ready1), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1), .fifo_count(count1)
  );

  uart_tx_param #(
    .DATA_W(DW), .BAUD_DIV(DIV), .STOP_BITS(2), .FIFO_DEPTH(DEP)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(valid2),
    .in_ready(ready2), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2), .fifo_count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic frame_t mk_frame(input logic [7:0] d, input logic pe, input logic odd,
                                      input int stops);
    frame_t f;
    int n;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pe) begin
      f.bits[n] = (^d) ^ odd;
      n++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = 4'(n);
    return f;
  endfunction

  task automatic wait_idle(input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (m_busy === 1'b0) seen = 1;
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Line monitor: on a start bit, pop the expected frame and sample each bit.
  initial begin : monitor
    frame_t      f;
    logic [11:0] obs;
    logic        first;
    bit          stable, abort, have;
    have = 0;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (mon_en && reset_n === 1'b1 && m_tx === 1'b0) begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) begin
          for (int c = 0; c < 200 && m_busy === 1'b1; c++) @(negedge clk);
        end else begin
          f      = exp_q.pop_front();
          obs    = '0;
          stable = 1;
          abort  = 0;
          first  = 1'b0;
          for (int b = 0; b < int'(f.nbits) && !abort; b++) begin
            for (int k = 0; k < DIV && !abort; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (reset_n !== 1'b1) begin
                abort = 1;
              end else begin
                if (k == DIV / 2) obs[b] = m_tx;
                if (k == 0) first = m_tx;
                else if (m_tx !== first) stable = 0;
                if (m_busy !== 1'b1) stable = 0;
                if ((b != 0 || k != 0) && m_done !== 1'b0) stable = 0;
              end
            end
          end
          if (!abort) begin
            check("frame_bits", 32'(obs), 32'(f.bits));
            check("bit_timing", 32'(stable), 32'd1);
            @(negedge clk);
            if (reset_n === 1'b1) check("tx_done_pulse", 32'(m_done), 32'd1);
            have = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] words[6];
    bit         got;
    bit         quiet;
    int         busy_cnt;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_count", 32'(count1), 32'd0);
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_tx2", 32'(tx2), 32'd1);
    check("rst_ready2", 32'(ready2), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // 0xA5, no parity
    @(negedge clk);
    in_data = 8'hA5; valid1 = 1'b1;
    exp_q.push_back(mk_frame(8'hA5, 1'b0, 1'b0, 1));
    @(negedge clk);
    valid1 = 1'b0;
    check("write_tx_high", 32'(tx1), 32'd1);
    check("write_count", 32'(count1), 32'd1);
    @(negedge clk);
    check("start_fall", 32'(tx1), 32'd0);
    check("start_busy", 32'(busy1), 32'd1);
    check("start_popped", 32'(count1), 32'd0);
    wait_idle(200);
    check("idle_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done1), 32'd0);

    // 0x07 even then odd parity, with the parity inputs flipped mid-frame
    in_data = 8'h07; parity_en = 1'b1; parity_odd = 1'b0; valid1 = 1'b1;
    exp_q.push_back(mk_frame(8'h07, 1'b1, 1'b0, 1));
    @(negedge clk);
    valid1 = 1'b0;
    repeat (10) @(negedge clk);
    parity_en = 1'b0; parity_odd = 1'b1;
    wait_idle(200);
    @(negedge clk);
    in_data = 8'h07; parity_en = 1'b1; parity_odd = 1'b1; valid1 = 1'b1;
    exp_q.push_back(mk_frame(8'h07, 1'b1, 1'b1, 1));
    @(negedge clk);
    valid1 = 1'b0;
    repeat (20) @(negedge clk);
    parity_en = 1'b0; parity_odd = 1'b0;
    wait_idle(200);
    @(negedge clk);

    // Six words on consecutive cycles: sixth waits for the first tx_done
    for (int i = 0; i < 5; i++) begin
      in_data = words[i]; valid1 = 1'b1;
      check("ready_accept", 32'(ready1), 32'd1);
      exp_q.push_back(mk_frame(words[i], 1'b0, 1'b0, 1));
      @(negedge clk);
    end
    in_data = words[5];
    check("ready_full", 32'(ready1), 32'd0);
    check("count_full", 32'(count1), 32'd4);
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (ready1 === 1'b1) got = 1;
      else @(negedge clk);
    end
    check("ready_returns", 32'(got), 32'd1);
    check("ready_on_done", 32'(done1), 32'd1);
    exp_q.push_back(mk_frame(words[5], 1'b0, 1'b0, 1));
    @(negedge clk);
    valid1 = 1'b0;
    wait_idle(1000);
    @(negedge clk);

    // Two stop bits, two words back-to-back
    sel = 1'b1;
    @(negedge clk);
    in_data = 8'h3C; valid2 = 1'b1;
    exp_q.push_back(mk_frame(8'h3C, 1'b0, 1'b0, 2));
    @(negedge clk);
    in_data = 8'hC3;
    exp_q.push_back(mk_frame(8'hC3, 1'b0, 1'b0, 2));
    @(negedge clk);
    valid2 = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy2 !== 1'b1) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_span_2stop", 32'(busy_cnt), 32'd88);
    check("count2_empty", 32'(count2), 32'd0);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Reset during data bit 3 with two words still queued
    in_data = 8'h5A; valid1 = 1'b1;
    exp_q.push_back(mk_frame(8'h5A, 1'b0, 1'b0, 1));
    @(negedge clk);
    in_data = 8'h96;
    exp_q.push_back(mk_frame(8'h96, 1'b0, 1'b0, 1));
    @(negedge clk);
    in_data = 8'h0F;
    exp_q.push_back(mk_frame(8'h0F, 1'b0, 1'b0, 1));
    @(negedge clk);
    valid1 = 1'b0;
    repeat (16) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx1), 32'd1);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_count", 32'(count1), 32'd0);
    check("abort_ready", 32'(ready1), 32'd1);
    check("abort_done", 32'(done1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    quiet = 1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) quiet = 0;
    end
    check("quiet_after_reset", 32'(quiet), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
